cpu_instr_fetch: RTL and testbench

Instruction fetch stage of the CPU. Drives the address port of the dual-word instruction memory, which returns `mem[addr]` and `mem[addr+1]` one clock after the address is presented. Assembles one- or two-word instructions and hands them to decode through a registered valid/ready interface. Accepts jump redirects from downstream and sustains one instruction per cycle when decode never stalls.

---
 rtl/cpu_instr_fetch.sv | 133 +++++++++++++
 tb/tb_cpu_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instr_fetch.sv
// cpu_instr_fetch
// ---------------
// Instruction fetch stage. Presents an address to a dual-word instruction
// memory (mem[addr] and mem[addr+1] return one clock later), assembles one-
// or two-word instructions and holds them in a registered output stage for
// decode. Jump redirects from downstream discard the buffered instruction
// and restart fetching at the target.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   mem_addr     : combinational address to the instruction memory
//   mem_data_0   : mem[addr] for the address presented last cycle
//   mem_data_1   : mem[addr+1] for the address presented last cycle
//   jump_valid   : redirect request (pulse or held)
//   jump_addr    : redirect target
//   instr_valid  : output register holds an instruction
//   instr_ready  : decode accepts the instruction this cycle
//   instr_word_0 : first instruction word
//   instr_word_1 : second word when long, 0 when short
//   instr_long   : instruction is two words
//   instr_pc     : address of instr_word_0
//   dbg_stream   : fetch phase (0 = EMPTY after reset, 1 = STREAM)
//
// Handshake: an instruction transfers on every rising edge where
// instr_valid and instr_ready are both 1. instr_valid and the payload are
// registered and stay stable while instr_valid=1 and instr_ready=0.
module cpu_instr_fetch #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_0,
    input  logic [DATA_WIDTH-1:0] mem_data_1,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_word_0,
    output logic [DATA_WIDTH-1:0] instr_word_1,
    output logic                  instr_long,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  dbg_stream
);

    // EMPTY: memory data does not yet correspond to r_pc (only after reset).
    // STREAM: memory data is valid for r_pc every cycle from then on.
    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_word_0;
    logic [DATA_WIDTH-1:0] r_word_1;
    logic                  r_long;
    logic [ADDR_WIDTH-1:0] r_instr_pc;

    logic                  w_long;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_advance;
    logic [ADDR_WIDTH-1:0] w_mem_addr;

    // Length of the instruction whose first word is on mem_data_0.
    // The add wraps naturally at 2^ADDR_WIDTH.
    assign w_long   = mem_data_0[DATA_WIDTH-1];
    assign w_pc_inc = r_pc + (w_long ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next phase, advance decision and memory address. When nothing moves,
    // the memory is pointed at r_pc again so the data it returns next cycle
    // still belongs to r_pc.
    always_comb begin
        w_state_next = ST_STREAM;
        w_advance    = 1'b0;
        w_mem_addr   = r_pc;
        if (r_state == ST_STREAM) begin
            w_advance = (!r_valid || instr_ready) && !jump_valid;
        end
        if (jump_valid) begin
            w_mem_addr = jump_addr;
        end else if (w_advance) begin
            w_mem_addr = w_pc_inc;
        end
    end

    // Jump wins over advance; a handshake in the jump cycle simply completes
    // because the buffered instruction is dropped either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_word_0   <= '0;
            r_word_1   <= '0;
            r_long     <= 1'b0;
            r_instr_pc <= '0;
        end else if (jump_valid) begin
            r_pc    <= jump_addr;
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_word_0   <= mem_data_0;
            r_word_1   <= w_long ? mem_data_1 : '0;
            r_long     <= w_long;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= w_pc_inc;
        end else if (r_valid && instr_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign mem_addr     = w_mem_addr;
    assign instr_valid  = r_valid;
    assign instr_word_0 = r_word_0;
    assign instr_word_1 = r_word_1;
    assign instr_long   = r_long;
    assign instr_pc     = r_instr_pc;
    assign dbg_stream   = (r_state == ST_STREAM);

endmodule

// File: tb/tb_cpu_instr_fetch.sv
// Bench for cpu_instr_fetch: directed scenarios followed by randomized
// ready/jump traffic, checked against an instruction-stream model that walks
// the memory image by instruction length.
module tb_cpu_instr_fetch;
    localparam int DW = 16;
    localparam int AW = 10;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_0;
    logic [DW-1:0] mem_data_1;
    logic          jump_valid  = 1'b0;
    logic [AW-1:0] jump_addr   = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_word_0;
    logic [DW-1:0] instr_word_1;
    logic          instr_long;
    logic [AW-1:0] instr_pc;
    logic          dbg_stream;

    cpu_instr_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC('0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_data_0   (mem_data_0),
        .mem_data_1   (mem_data_1),
        .jump_valid   (jump_valid),
        .jump_addr    (jump_addr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_word_0 (instr_word_0),
        .instr_word_1 (instr_word_1),
        .instr_long   (instr_long),
        .instr_pc     (instr_pc),
        .dbg_stream   (dbg_stream)
    );

    // ---------------- dual-word memory, one-cycle read ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] mem_addr_p1;
    assign mem_addr_p1 = mem_addr + 10'd1;
    always @(posedge clk) begin
        mem_data_0 <= mem[mem_addr];
        mem_data_1 <= mem[mem_addr_p1];
    end

    // ---------------- scoreboard / model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // m_pc: address of the instruction decode should see next
    logic [AW-1:0] m_pc;
    logic          m_valid;
    logic          m_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_valid = 1'b0;
        m_first = 1'b1;
    endtask

    task automatic check_outputs();
        logic [DW-1:0] w0;
        logic [AW-1:0] a1;
        chk("valid", 32'(instr_valid), 32'(m_valid));
        chk("stream", 32'(dbg_stream), 32'd1);
        if (m_valid) begin
            w0 = mem[m_pc];
            a1 = m_pc + 10'd1;
            chk("pc", 32'(instr_pc), 32'(m_pc));
            chk("word0", 32'(instr_word_0), 32'(w0));
            chk("long", 32'(instr_long), 32'(w0[DW-1]));
            chk("word1", 32'(instr_word_1), w0[DW-1] ? 32'(mem[a1]) : 32'd0);
        end
    endtask

    // One clock: drive at negedge, let the edge happen, update model, check.
    task automatic step(input logic rdy, input logic jv, input logic [AW-1:0] ja);
        logic          hs;
        logic [DW-1:0] w0;
        @(negedge clk);
        instr_ready = rdy;
        jump_valid  = jv;
        jump_addr   = ja;
        hs = m_valid && rdy;
        @(posedge clk);
        #1;
        if (hs) begin
            w0   = mem[m_pc];
            m_pc = m_pc + (w0[DW-1] ? 10'd2 : 10'd1);
        end
        if (jv) begin
            m_pc    = ja;
            m_valid = 1'b0;
        end else begin
            m_valid = !m_first;
        end
        m_first = 1'b0;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_w0"}, 32'(instr_word_0), 32'd0);
        chk({tag, "_w1"}, 32'(instr_word_1), 32'd0);
        chk({tag, "_long"}, 32'(instr_long), 32'd0);
        chk({tag, "_pc"}, 32'(instr_pc), 32'd0);
        chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_stream"}, 32'(dbg_stream), 32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2;
        jump_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_reset_values(tag);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic          rdy;
        logic          jv;
        logic [AW-1:0] ja;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[0] = 16'h0001;
        mem[1] = 16'h8002;
        mem[2] = 16'h1234;
        mem[3] = 16'h0003;
        model_reset();
        #1;
        check_reset_values("por");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Startup and back-to-back stream
        step(1'b1, 1'b0, '0);
        chk("start_edge1_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("seq_pc0", 32'(instr_pc), 32'h000);
        chk("seq_w0_0001", 32'(instr_word_0), 32'h0001);
        chk("seq_w1_short0", 32'(instr_word_1), 32'h0000);
        step(1'b1, 1'b0, '0);
        chk("seq_pc1", 32'(instr_pc), 32'h001);
        chk("seq_w1_1234", 32'(instr_word_1), 32'h1234);

        // Stall five cycles with pc 1 buffered
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        chk("stall_pc1", 32'(instr_pc), 32'h001);
        chk("stall_w0", 32'(instr_word_0), 32'h8002);
        step(1'b1, 1'b0, '0);
        chk("after_stall_pc3", 32'(instr_pc), 32'h003);
        chk("after_stall_valid", 32'(instr_valid), 32'd1);

        // Jump while pc 3 is buffered and not accepted
        step(1'b0, 1'b1, 10'h200);
        chk("jump_drop_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("jump_target_pc", 32'(instr_pc), 32'h200);

        // Jump together with a handshake in an advance cycle
        step(1'b1, 1'b1, 10'h010);
        chk("jump_hs_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("jump_hs_pc", 32'(instr_pc), 32'h010);

        // Reset mid-stream, then wrap-around at the top address
        pulse_reset("mid");
        mem[0]     = 16'h5555;
        mem[10'h3FF] = 16'h8ABC;
        step(1'b1, 1'b0, '0);
        chk("restart_edge1_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("restart_pc0", 32'(instr_pc), 32'h000);
        chk("restart_w0", 32'(instr_word_0), 32'h5555);
        step(1'b1, 1'b1, 10'h3FF);
        step(1'b1, 1'b0, '0);
        chk("wrap_pc", 32'(instr_pc), 32'h3FF);
        chk("wrap_long", 32'(instr_long), 32'd1);
        chk("wrap_w1", 32'(instr_word_1), 32'h5555);
        step(1'b1, 1'b0, '0);
        chk("wrap_next_pc", 32'(instr_pc), 32'h001);

        // Randomized ready/jump traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) pulse_reset("rnd");
            rdy = ($urandom_range(0, 3) != 0);
            jv  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) ja = 10'h3FE + 10'($urandom_range(0, 1));
            else                           ja = 10'($urandom_range(0, 1023));
            step(rdy, jv, ja);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout reached before end of stimulus");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end
endmodule
